mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single-port data/instruction RAM shared by the IF stage (instruction fetch, read-only) and the MEM stage (load/store). It serialises requests onto one RAM port and waits out the fixed RAM read latency. It returns data with a one-cycle valid pulse and produces per-stage stall signals for the pipeline control. The returned MEM data feeds the MEM/WB pipeline register.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 58 +++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/MEM request channels and RAM port of the shared memory arbiter
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_gnt_o;
  logic        mem_rvalid_o;
  logic [31:0] mem_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        stall_if_o;
  logic        stall_mem_o;
  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_wstrb_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, mem_gnt_o, mem_rvalid_o, mem_rdata_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_if_o, stall_mem_o
  );
  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_wstrb_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, mem_gnt_o, mem_rvalid_o, mem_rdata_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_if_o, stall_mem_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and MEM loads/stores onto one fixed-latency RAM port
module mem_port_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input logic clk_i,
  input logic rst_i,
  mem_port_arbiter_if.slave p
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t     state, nxt;
  logic [2:0] cnt;
  logic [3:0] starve_cnt;
  logic       win_mem, win_st, sel_mem, issue, fin;
  assign sel_mem = p.mem_req_i & ~(p.if_req_i & (starve_cnt == 4'(STARVE_MAX)));
  assign issue   = (state == IDLE) & (p.if_req_i | p.mem_req_i) & ~rst_i;
  assign fin     = (state == WAIT) & (cnt == 3'(LAT));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (issue ? WAIT : IDLE) :
          state == WAIT ? (fin ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    p.if_gnt_o    = issue & ~sel_mem;
    p.mem_gnt_o   = issue & sel_mem;
    p.ram_en_o    = issue;
    p.ram_we_o    = issue & sel_mem & p.mem_we_i ? p.mem_wstrb_i : 4'b0;
    p.ram_addr_o  = ~issue ? 32'b0 : sel_mem ? p.mem_addr_i : p.if_addr_i;
    p.ram_wdata_o = issue & sel_mem ? p.mem_wdata_i : 32'b0;
  end
  assign p.stall_if_o  = p.if_req_i & ~p.if_rvalid_o;
  assign p.stall_mem_o = p.mem_req_i & ~p.mem_rvalid_o;
  // Stores complete with zero data so MEM/WB never sees stale RAM output
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt           <= '0;
      starve_cnt    <= '0;
      win_mem       <= 1'b0;
      win_st        <= 1'b0;
      p.if_rvalid_o  <= 1'b0;
      p.mem_rvalid_o <= 1'b0;
      p.if_rdata_o   <= '0;
      p.mem_rdata_o  <= '0;
    end else begin
      p.if_rvalid_o  <= fin & ~win_mem;
      p.mem_rvalid_o <= fin & win_mem;
      if (issue) begin
        cnt        <= 3'd1;
        win_mem    <= sel_mem;
        win_st     <= sel_mem & p.mem_we_i;
        starve_cnt <= sel_mem & p.if_req_i ? starve_cnt + {3'b0, starve_cnt != 4'hF} : 4'b0;
      end else if (state == WAIT) cnt <= cnt + 3'd1;
      if (fin & win_mem)  p.mem_rdata_o <= win_st ? 32'b0 : p.ram_rdata_i;
      if (fin & ~win_mem) p.if_rdata_o  <= p.ram_rdata_i;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, stores and reset abort
module tb_mem_port_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   pass_n = 0;
  int   total_n = 0;
  always #5 clk_i = ~clk_i;
  mem_port_arbiter_if a();
  mem_port_arbiter_if b();
  mem_port_arbiter #(.LAT(2), .STARVE_MAX(2)) dut_a (.clk_i(clk_i), .rst_i(rst_i), .p(a));
  mem_port_arbiter #(.LAT(1), .STARVE_MAX(4)) dut_b (.clk_i(clk_i), .rst_i(rst_i), .p(b));

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    a.if_req_i = 0; a.if_addr_i = 0; a.mem_req_i = 0; a.mem_we_i = 0; a.mem_wstrb_i = 0;
    a.mem_addr_i = 0; a.mem_wdata_i = 0; a.ram_rdata_i = 0;
    b.if_req_i = 0; b.if_addr_i = 0; b.mem_req_i = 0; b.mem_we_i = 0; b.mem_wstrb_i = 0;
    b.mem_addr_i = 0; b.mem_wdata_i = 0; b.ram_rdata_i = 0;
  endtask

  task automatic do_reset;
    tick;
    rst_i = 1;
    clear_inputs;
    tick;
    rst_i = 0;
  endtask

  task automatic test_reset;
    tick;
    rst_i = 1;
    a.if_req_i = 1; a.mem_req_i = 1; a.mem_we_i = 1; a.mem_wstrb_i = 4'hF; a.mem_addr_i = 32'h44;
    @(negedge clk_i);
    total_n++; if (a.if_gnt_o !== 0 || a.mem_gnt_o !== 0) $display("FAIL reset_gnt: got %b%b want 00", a.if_gnt_o, a.mem_gnt_o); else pass_n++;
    total_n++; if ({a.ram_en_o, a.ram_we_o, a.ram_addr_o, a.ram_wdata_o} !== '0) $display("FAIL reset_ram: got en=%b we=%h addr=%h want 0", a.ram_en_o, a.ram_we_o, a.ram_addr_o); else pass_n++;
    total_n++; if ({a.if_rvalid_o, a.mem_rvalid_o, b.if_rvalid_o, b.mem_rvalid_o} !== 4'b0) $display("FAIL reset_rvalid: got nonzero want 0"); else pass_n++;
    total_n++; if ({a.if_rdata_o, a.mem_rdata_o} !== 64'b0) $display("FAIL reset_rdata: got %h %h want 0", a.if_rdata_o, a.mem_rdata_o); else pass_n++;
    total_n++; if (dut_a.starve_cnt !== 0) $display("FAIL reset_starve: got %0d want 0", dut_a.starve_cnt); else pass_n++;
    clear_inputs;
    tick;
    rst_i = 0;
  endtask

  task automatic test_if_read;
    do_reset;
    for (int c = 0; c <= 4; c++) begin
      tick;
      a.if_req_i = c <= 3;
      a.if_addr_i = 32'h40;
      a.ram_rdata_i = c == 2 ? 32'hDEADBEEF : 32'h0;
      @(negedge clk_i);
      if (c == 0) begin
        total_n++; if (a.if_gnt_o !== 1 || a.ram_en_o !== 1 || a.ram_addr_o !== 32'h40 || a.ram_we_o !== 0) $display("FAIL ifrd_issue: got gnt=%b en=%b addr=%h we=%h want 1 1 40 0", a.if_gnt_o, a.ram_en_o, a.ram_addr_o, a.ram_we_o); else pass_n++;
      end else begin
        total_n++; if (a.if_gnt_o !== 0 || a.ram_en_o !== 0 || a.ram_addr_o !== 0) $display("FAIL ifrd_quiet c%0d: got gnt=%b en=%b addr=%h want 0", c, a.if_gnt_o, a.ram_en_o, a.ram_addr_o); else pass_n++;
      end
      total_n++; if (a.if_rvalid_o !== (c == 3)) $display("FAIL ifrd_rvalid c%0d: got %b want %b", c, a.if_rvalid_o, c == 3); else pass_n++;
      total_n++; if (a.stall_if_o !== (c <= 2)) $display("FAIL ifrd_stall c%0d: got %b want %b", c, a.stall_if_o, c <= 2); else pass_n++;
      if (c >= 3) begin
        total_n++; if (a.if_rdata_o !== 32'hDEADBEEF) $display("FAIL ifrd_rdata c%0d: got %h want deadbeef", c, a.if_rdata_o); else pass_n++;
      end
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    for (int c = 0; c <= 7; c++) begin
      tick;
      a.mem_req_i = c <= 3;
      a.mem_addr_i = 32'h200;
      a.if_req_i = 1;
      a.if_addr_i = 32'h80;
      a.ram_rdata_i = 32'hA0000000 + c;
      @(negedge clk_i);
      total_n++; if (a.mem_gnt_o !== (c == 0) || a.if_gnt_o !== (c == 4)) $display("FAIL sim_gnt c%0d: got mem=%b if=%b want %b %b", c, a.mem_gnt_o, a.if_gnt_o, c == 0, c == 4); else pass_n++;
      total_n++; if (a.mem_rvalid_o !== (c == 3) || a.if_rvalid_o !== (c == 7)) $display("FAIL sim_rvalid c%0d: got mem=%b if=%b want %b %b", c, a.mem_rvalid_o, a.if_rvalid_o, c == 3, c == 7); else pass_n++;
      if (c == 4) begin
        total_n++; if (a.ram_addr_o !== 32'h80) $display("FAIL sim_ifaddr: got %h want 80", a.ram_addr_o); else pass_n++;
      end
    end
    total_n++; if (a.mem_rdata_o !== 32'hA0000002) $display("FAIL sim_memdata: got %h want a0000002", a.mem_rdata_o); else pass_n++;
    total_n++; if (a.if_rdata_o !== 32'hA0000006) $display("FAIL sim_ifdata: got %h want a0000006", a.if_rdata_o); else pass_n++;
  endtask

  task automatic test_starvation;
    do_reset;
    for (int c = 0; c <= 9; c++) begin
      tick;
      a.if_req_i = 1;
      a.mem_req_i = 1;
      @(negedge clk_i);
      total_n++; if (a.mem_gnt_o !== (c == 0 || c == 4) || a.if_gnt_o !== (c == 8)) $display("FAIL starve_gnt c%0d: got mem=%b if=%b want %b %b", c, a.mem_gnt_o, a.if_gnt_o, c == 0 || c == 4, c == 8); else pass_n++;
      if (c == 5) begin
        total_n++; if (dut_a.starve_cnt !== 4'd2) $display("FAIL starve_cnt_max: got %0d want 2", dut_a.starve_cnt); else pass_n++;
      end
    end
    total_n++; if (dut_a.starve_cnt !== 4'd0) $display("FAIL starve_cnt_clr: got %0d want 0", dut_a.starve_cnt); else pass_n++;
    clear_inputs;
  endtask

  task automatic test_store;
    do_reset;
    for (int c = 0; c <= 7; c++) begin
      tick;
      a.mem_req_i = 1;
      a.mem_we_i = c >= 4;
      a.mem_wstrb_i = 4'b0011;
      a.mem_addr_i = c >= 4 ? 32'h100 : 32'h20;
      a.mem_wdata_i = 32'h12345678;
      a.ram_rdata_i = 32'hFFFFFFFF;
      @(negedge clk_i);
      if (c >= 4) begin
        total_n++; if (a.ram_we_o !== (c == 4 ? 4'b0011 : 4'b0000)) $display("FAIL st_we c%0d: got %b want %b", c, a.ram_we_o, c == 4 ? 4'b0011 : 4'b0000); else pass_n++;
        total_n++; if (a.mem_rvalid_o !== (c == 7)) $display("FAIL st_rvalid c%0d: got %b want %b", c, a.mem_rvalid_o, c == 7); else pass_n++;
      end
      if (c == 3) begin
        total_n++; if (a.mem_rvalid_o !== 1 || a.mem_rdata_o !== 32'hFFFFFFFF) $display("FAIL ld_before_st: got v=%b d=%h want 1 ffffffff", a.mem_rvalid_o, a.mem_rdata_o); else pass_n++;
      end
      if (c == 4) begin
        total_n++; if (a.mem_gnt_o !== 1 || a.ram_addr_o !== 32'h100 || a.ram_wdata_o !== 32'h12345678) $display("FAIL st_issue: got gnt=%b addr=%h wdata=%h want 1 100 12345678", a.mem_gnt_o, a.ram_addr_o, a.ram_wdata_o); else pass_n++;
      end
    end
    total_n++; if (a.mem_rdata_o !== 32'h0) $display("FAIL st_rdata: got %h want 0", a.mem_rdata_o); else pass_n++;
    clear_inputs;
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int c = 0; c <= 10; c++) begin
      tick;
      rst_i = c == 1 || c == 2;
      a.if_req_i = c <= 1 || c >= 7;
      a.if_addr_i = c >= 7 ? 32'h84 : 32'h80;
      a.ram_rdata_i = 32'hC0FFEE00;
      @(negedge clk_i);
      if (c == 1) begin
        total_n++; if (a.if_gnt_o !== 0 || a.ram_en_o !== 0 || a.ram_addr_o !== 0 || a.if_rvalid_o !== 0 || a.if_rdata_o !== 0) $display("FAIL rstmid_out: got gnt=%b en=%b addr=%h v=%b d=%h want 0", a.if_gnt_o, a.ram_en_o, a.ram_addr_o, a.if_rvalid_o, a.if_rdata_o); else pass_n++;
      end
      if (c >= 2 && c <= 6) begin
        total_n++; if (a.if_rvalid_o !== 0 || a.if_gnt_o !== 0) $display("FAIL rstmid_quiet c%0d: got v=%b gnt=%b want 0 0", c, a.if_rvalid_o, a.if_gnt_o); else pass_n++;
      end
      if (c == 7) begin
        total_n++; if (a.if_gnt_o !== 1 || a.ram_addr_o !== 32'h84) $display("FAIL rstmid_fresh: got gnt=%b addr=%h want 1 84", a.if_gnt_o, a.ram_addr_o); else pass_n++;
      end
      if (c == 10) begin
        total_n++; if (a.if_rvalid_o !== 1 || a.if_rdata_o !== 32'hC0FFEE00) $display("FAIL rstmid_done: got v=%b d=%h want 1 c0ffee00", a.if_rvalid_o, a.if_rdata_o); else pass_n++;
      end
    end
    clear_inputs;
  endtask

  task automatic test_back_to_back;
    do_reset;
    for (int c = 0; c <= 8; c++) begin
      tick;
      b.mem_req_i = 1;
      b.mem_addr_i = 32'(c / 3 * 4);
      b.ram_rdata_i = 32'hB0000000 + c;
      @(negedge clk_i);
      total_n++; if (b.mem_gnt_o !== (c % 3 == 0)) $display("FAIL b2b_gnt c%0d: got %b want %b", c, b.mem_gnt_o, c % 3 == 0); else pass_n++;
      total_n++; if (b.mem_rvalid_o !== (c % 3 == 2)) $display("FAIL b2b_rvalid c%0d: got %b want %b", c, b.mem_rvalid_o, c % 3 == 2); else pass_n++;
      if (c % 3 == 0) begin
        total_n++; if (b.ram_addr_o !== 32'(c / 3 * 4)) $display("FAIL b2b_addr c%0d: got %h want %h", c, b.ram_addr_o, c / 3 * 4); else pass_n++;
      end
      if (c % 3 == 2) begin
        total_n++; if (b.mem_rdata_o !== 32'hB0000000 + c - 1) $display("FAIL b2b_data c%0d: got %h want %h", c, b.mem_rdata_o, 32'hB0000000 + c - 1); else pass_n++;
      end
    end
    clear_inputs;
  endtask

  initial begin
    clear_inputs;
    tick;
    test_reset;
    test_if_read;
    test_simultaneous;
    test_starvation;
    test_store;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
